// File: rtl/pipeline_chain_if.sv
// Stream bundle for pipeline_chain: upstream word in, downstream word out, flush and occupancy.
// slave is the pipeline's view; master is the view of whatever drives and consumes it.
interface pipeline_chain_if #(
  parameter int DW = 32,
  parameter int CW = 2
);
  logic          i_valid;
  logic          i_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic          i_flush;
  logic [CW-1:0] o_count;

  modport slave (
    input  i_valid, i_data, o_ready, i_flush,
    output i_ready, o_valid, o_data, o_count
  );

  modport master (
    output i_valid, i_data, o_ready, i_flush,
    input  i_ready, o_valid, o_data, o_count
  );
endinterface

// File: rtl/pipeline_chain.sv
// DEPTH-stage in-order valid/ready register pipeline, DEPTH cycles in to out, one word per cycle.
// SKID=0 passes ready back combinationally; SKID=1 adds a skid slot per stage so i_ready is a flop.
module pipeline_chain #(
  parameter int DW    = 32,
  parameter int DEPTH = 2,
  parameter int SKID  = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  pipeline_chain_if.slave bus
);
  localparam int CAP = DEPTH * (1 + SKID);
  localparam int CW  = $clog2(CAP + 1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] sv_q, sv_d;
  logic [DW-1:0]    d_q  [DEPTH];
  logic [DW-1:0]    d_d  [DEPTH];
  logic [DW-1:0]    sd_q [DEPTH];
  logic [DW-1:0]    sd_d [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] vin;
  logic [DW-1:0]    din [DEPTH];
  logic [DEPTH-1:0] take;
  logic [DEPTH-1:0] drain;
  logic             in_xfer;
  logic             out_xfer;

  // rdy[k] is "stage k can accept"; the top entry is the downstream ready.
  always_comb begin
    rdy[DEPTH] = bus.o_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy[k] = (SKID != 0) ? !sv_q[k] : (!v_q[k] || rdy[k+1]);
    end
  end

  assign bus.i_ready = rdy[0] && !bus.i_flush;
  assign in_xfer     = bus.i_valid && bus.i_ready;
  assign out_xfer    = v_q[DEPTH-1] && bus.o_ready;

  always_comb begin
    vin    = '0;
    take   = '0;
    drain  = '0;
    v_d    = v_q;
    sv_d   = sv_q;
    d_d    = d_q;
    sd_d   = sd_q;
    vin[0] = in_xfer;
    din[0] = bus.i_data;
    for (int k = 1; k < DEPTH; k++) begin
      vin[k] = v_q[k-1];
      din[k] = d_q[k-1];
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (SKID == 0) begin
        if (rdy[k]) v_d[k] = vin[k];
        if (rdy[k] && vin[k]) d_d[k] = din[k];
      end else begin
        take[k]  = vin[k] && !sv_q[k];
        drain[k] = v_q[k] && rdy[k+1];
        if (drain[k] && sv_q[k]) begin
          d_d[k]  = sd_q[k];
          v_d[k]  = 1'b1;
          sv_d[k] = 1'b0;
        end else if (take[k]) begin
          if (!v_q[k] || drain[k]) begin
            d_d[k] = din[k];
            v_d[k] = 1'b1;
          end else begin
            sd_d[k] = din[k];
            sv_d[k] = 1'b1;
          end
        end else if (drain[k]) begin
          v_d[k] = 1'b0;
        end
      end
    end
    // Flush empties every slot but freezes the data registers, so o_data keeps its last word.
    if (bus.i_flush) begin
      v_d  = '0;
      sv_d = '0;
      d_d  = d_q;
      sd_d = sd_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.i_flush) begin
      cnt_d = '0;
    end else if (in_xfer && !out_xfer) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!in_xfer && out_xfer) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      sv_q  <= '0;
      cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k]  <= '0;
        sd_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      sv_q  <= sv_d;
      cnt_q <= cnt_d;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k]  <= d_d[k];
        sd_q[k] <= sd_d[k];
      end
    end
  end

  assign bus.o_valid = v_q[DEPTH-1];
  assign bus.o_data  = d_q[DEPTH-1];
  assign bus.o_count = cnt_q;
endmodule

// File: tb/tb_pipeline_chain.sv
// Directed and randomized checks of pipeline_chain across ten DEPTH/SKID configurations.
// One shared driver set is steered to the selected instance; idle instances see no traffic.
module tb_pipeline_chain;
  localparam int NCFG = 10;

  function automatic int cfg_depth(input int c);
    case (c)
      0, 1:    return 3;
      2, 3:    return 2;
      4, 5:    return 1;
      6, 7:    return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_skid(input int c);
    return c % 2;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          sel = 0;
  logic        drv_vld = 1'b0;
  logic [31:0] drv_dat = '0;
  logic        drv_flush = 1'b0;
  logic        drv_ordy = 1'b0;

  logic        obs_irdy [NCFG];
  logic        obs_ovld [NCFG];
  logic [31:0] obs_dat  [NCFG];
  logic [7:0]  obs_cnt  [NCFG];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar c = 0; c < NCFG; c++) begin : g
    localparam int D  = cfg_depth(c);
    localparam int S  = cfg_skid(c);
    localparam int CW = $clog2(D * (1 + S) + 1);

    pipeline_chain_if #(.DW(32), .CW(CW)) bus ();

    pipeline_chain #(.DW(32), .DEPTH(D), .SKID(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    assign bus.i_valid = (sel == c) && drv_vld;
    assign bus.i_data  = drv_dat;
    assign bus.i_flush = (sel == c) && drv_flush;
    assign bus.o_ready = (sel == c) && drv_ordy;
    assign obs_irdy[c] = bus.i_ready;
    assign obs_ovld[c] = bus.o_valid;
    assign obs_dat[c]  = bus.o_data;
    assign obs_cnt[c]  = 8'(bus.o_count);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cfg=%0d got=0x%0h expected=0x%0h", tag, sel, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int clamp16(input int x);
    return (x < 0) ? 0 : ((x > 16) ? 16 : x);
  endfunction

  task automatic stream_test(input int c);
    int d, w;
    logic exp_v;
    sel = c;
    d = cfg_depth(c);
    drv_ordy = 1'b1;
    for (int cy = 0; cy < 16 + d + 1; cy++) begin
      drv_vld = (cy < 16);
      drv_dat = cy;
      @(negedge clk);
      w = cy - d;
      exp_v = (w >= 0) && (w < 16);
      check_eq("str_vld", obs_ovld[sel], exp_v);
      if (exp_v) check_eq("str_dat", obs_dat[sel], w);
      if (cy < 16) check_eq("str_irdy", obs_irdy[sel], 1);
      check_eq("str_cnt", obs_cnt[sel], clamp16(cy) - clamp16(cy - d));
      step();
    end
    drv_vld = 1'b0;
    drv_ordy = 1'b0;
  endtask

  task automatic rand_test(input int c, input int nwords);
    logic [31:0] q[$];
    logic [31:0] e;
    int sent, got, cyc, cap;
    bit did_rst, acc;
    sel = c;
    sent = 0;
    got = 0;
    cyc = 0;
    did_rst = 1'b0;
    cap = cfg_depth(c) * (1 + cfg_skid(c));
    drv_vld = 1'b0;
    drv_flush = 1'b0;
    while (got < nwords && cyc < 20000) begin
      cyc++;
      if (!drv_vld && sent < nwords && $urandom_range(1) == 1) begin
        drv_vld = 1'b1;
        drv_dat = $urandom;
      end
      drv_ordy = ($urandom_range(99) < 30);
      @(negedge clk);
      if (!did_rst && sent == nwords / 2) begin
        did_rst = 1'b1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_vld", obs_ovld[sel], 0);
        check_eq("rst_cnt", obs_cnt[sel], 0);
        check_eq("rst_dat", obs_dat[sel], 0);
        q.delete();
        sent = got;
        rst_n = 1'b1;
        #1;
      end
      check_eq("rnd_cnt", obs_cnt[sel], q.size());
      check_eq("rnd_cap", obs_cnt[sel] <= cap, 1);
      if (q.size() == 0) check_eq("rnd_empty_vld", obs_ovld[sel], 0);
      if (obs_ovld[sel] && drv_ordy && q.size() > 0) begin
        e = q.pop_front();
        check_eq("rnd_dat", obs_dat[sel], e);
        got++;
      end
      acc = drv_vld && obs_irdy[sel];
      if (acc) begin
        q.push_back(drv_dat);
        sent++;
      end
      step();
      if (acc) drv_vld = 1'b0;
    end
    check_eq("rnd_done", got, nwords);
    drv_vld = 1'b0;
    drv_ordy = 1'b0;
  endtask

  initial begin
    int idx_in, idx_out;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    sel = 0;
    check_eq("rst_o_valid", obs_ovld[0], 0);
    check_eq("rst_o_data", obs_dat[0], 0);
    check_eq("rst_o_count", obs_cnt[0], 0);
    check_eq("rst_i_ready", obs_irdy[0], 1);
    step();

    // Latency, DEPTH=3 SKID=0: accepted at edge 0, visible after edge 2.
    drv_ordy = 1'b1;
    drv_vld = 1'b1;
    drv_dat = 32'h1111_1111;
    @(negedge clk);
    check_eq("lat_irdy", obs_irdy[0], 1);
    step();
    drv_vld = 1'b0;
    @(negedge clk);
    check_eq("lat_e0_vld", obs_ovld[0], 0);
    step();
    @(negedge clk);
    check_eq("lat_e1_vld", obs_ovld[0], 0);
    step();
    @(negedge clk);
    check_eq("lat_e2_vld", obs_ovld[0], 1);
    check_eq("lat_e2_dat", obs_dat[0], 32'h1111_1111);
    check_eq("lat_e2_cnt", obs_cnt[0], 1);
    step();
    @(negedge clk);
    check_eq("lat_e3_vld", obs_ovld[0], 0);
    check_eq("lat_e3_hold", obs_dat[0], 32'h1111_1111);
    check_eq("lat_e3_cnt", obs_cnt[0], 0);
    step();
    drv_ordy = 1'b0;

    stream_test(0);
    stream_test(1);

    // Backpressure fill, DEPTH=2 SKID=1.
    sel = 3;
    drv_ordy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv_vld = 1'b1;
      drv_dat = 32'hA + i;
      @(negedge clk);
      check_eq("bp_fill_irdy", obs_irdy[sel], 1);
      step();
    end
    drv_dat = 32'hE;
    @(negedge clk);
    check_eq("bp_full_irdy", obs_irdy[sel], 0);
    check_eq("bp_full_cnt", obs_cnt[sel], 4);
    check_eq("bp_full_vld", obs_ovld[sel], 1);
    check_eq("bp_full_dat", obs_dat[sel], 32'hA);
    step();
    @(negedge clk);
    check_eq("bp_hold_irdy", obs_irdy[sel], 0);
    step();
    drv_ordy = 1'b1;
    idx_in = 4;
    idx_out = 0;
    for (int cy = 0; cy < 20 && idx_out < 6; cy++) begin
      drv_vld = (idx_in < 6);
      drv_dat = 32'hA + idx_in;
      @(negedge clk);
      if (obs_ovld[sel]) begin
        check_eq("bp_out", obs_dat[sel], 32'hA + idx_out);
        idx_out++;
      end
      if (drv_vld && obs_irdy[sel]) idx_in++;
      step();
    end
    check_eq("bp_all_out", idx_out, 6);
    drv_vld = 1'b0;
    @(negedge clk);
    check_eq("bp_empty_cnt", obs_cnt[sel], 0);
    step();
    drv_ordy = 1'b0;

    // Full with simultaneous in/out, DEPTH=2 SKID=0.
    sel = 2;
    for (int i = 1; i <= 2; i++) begin
      drv_vld = 1'b1;
      drv_dat = i;
      @(negedge clk);
      check_eq("full_fill_irdy", obs_irdy[sel], 1);
      step();
    end
    drv_dat = 3;
    @(negedge clk);
    check_eq("full_irdy_blocked", obs_irdy[sel], 0);
    check_eq("full_cnt", obs_cnt[sel], 2);
    step();
    drv_ordy = 1'b1;
    @(negedge clk);
    check_eq("full_irdy_pass", obs_irdy[sel], 1);
    check_eq("full_head", obs_dat[sel], 1);
    step();
    drv_vld = 1'b0;
    drv_ordy = 1'b0;
    @(negedge clk);
    check_eq("full_cnt_after", obs_cnt[sel], 2);
    check_eq("full_next", obs_dat[sel], 2);
    step();
    drv_ordy = 1'b1;
    @(negedge clk);
    check_eq("full_drain2", obs_dat[sel], 2);
    step();
    @(negedge clk);
    check_eq("full_drain3", obs_dat[sel], 3);
    step();
    @(negedge clk);
    check_eq("full_empty_vld", obs_ovld[sel], 0);
    check_eq("full_empty_cnt", obs_cnt[sel], 0);
    step();
    drv_ordy = 1'b0;

    // Flush, DEPTH=3 SKID=0 holding three words.
    sel = 0;
    for (int i = 0; i < 3; i++) begin
      drv_vld = 1'b1;
      drv_dat = 32'h21 + i;
      step();
    end
    drv_ordy = 1'b1;
    drv_dat = 32'h24;
    drv_flush = 1'b1;
    @(negedge clk);
    check_eq("fl_irdy", obs_irdy[sel], 0);
    check_eq("fl_head_vld", obs_ovld[sel], 1);
    check_eq("fl_head_dat", obs_dat[sel], 32'h21);
    check_eq("fl_cnt_before", obs_cnt[sel], 3);
    step();
    @(negedge clk);
    check_eq("fl_vld_after", obs_ovld[sel], 0);
    check_eq("fl_cnt_after", obs_cnt[sel], 0);
    check_eq("fl_dat_kept", obs_dat[sel], 32'h21);
    check_eq("fl_held_irdy", obs_irdy[sel], 0);
    step();
    drv_flush = 1'b0;
    drv_vld = 1'b0;
    @(negedge clk);
    check_eq("fl_release_irdy", obs_irdy[sel], 1);
    check_eq("fl_release_cnt", obs_cnt[sel], 0);
    check_eq("fl_release_vld", obs_ovld[sel], 0);
    step();
    drv_ordy = 1'b0;

    for (int c = 0; c < NCFG; c++) rand_test(c, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog cfg=%0d got=timeout expected=completion", sel);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/pipeline_chain.md
# pipeline_chain

Parametrised multi-stage valid/ready register pipeline, the successor to the single-stage 32-bit pipeline wrapper. It carries DW-bit words through DEPTH register stages with full one-word-per-cycle throughput and strict in-order delivery. An optional skid mode breaks the combinational ready path between ports. It adds a synchronous flush and an occupancy count. It is inserted wherever datapaths need timing cuts, for example between the RSA Montgomery core and its operand and result buses.

## Interface
- DW, 32, data width in bits (1..1024)
- DEPTH, 2, number of register stages (1..8)
- SKID, 0, 0 = plain stages, where ready propagates combinationally; 1 = skid stages, where i_ready depends only on registers
- CW, $clog2(DEPTH*(1+SKID)+1), width of o_count (localparam)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  upstream word valid
- i_ready  out  1  block can accept a word
- i_data  in  DW  upstream word
- o_valid  out  1  downstream word valid
- o_ready  in  1  downstream can accept
- o_data  out  DW  downstream word
- i_flush  in  1  synchronous discard of all held words
- o_count  out  CW  number of words currently held

## Operation
- Transfer rules: an input transfer occurs when i_valid && i_ready at a rising edge. An output transfer occurs when o_valid && o_ready at a rising edge.
- Stage k (0 = input side) holds a valid bit v[k] and a data register d[k]. Stage DEPTH-1 drives o_valid and o_data.
- Data registers load only on their enable. They never clear except on reset. o_data holds its last value while o_valid = 0.

SKID=0:
- Stage k accepts when !v[k] || r[k+1], where r[DEPTH] = o_ready.
- i_ready = !v[0] || r[1].
- Capacity is DEPTH words.

SKID=1:
- Each stage has a main slot (v, d) and a skid slot (sv, sd).
- The stage is ready iff !sv.
- On acceptance: the word goes to main if the main slot is empty or is being drained this cycle. Otherwise it goes to skid.
- When main drains and sv = 1, skid moves to main and sv clears.
- i_ready = !sv[0]. It is a pure register output.
- Capacity is 2*DEPTH words.

Common rules:
- Ordering: words leave in exact acceptance order. There is no reordering, duplication or loss except by flush.
- o_count increments on an input transfer and decrements on an output transfer. It is unchanged when both occur in the same cycle. It never exceeds capacity.

Flush:
- i_flush = 1 forces i_ready = 0 combinationally, so no input transfer occurs in that cycle.
- An output transfer in the flush cycle still completes normally.
- At the next edge, all v and sv clear and o_count becomes 0. Data registers keep their values.
- i_flush held for several cycles keeps the block empty and refusing input.

Reset:
- Asserting rst_n low mid-operation discards all words immediately (asynchronous).
- Reset values: o_valid = 0, o_data = 0, o_count = 0, all d and sd = 0, i_ready = 1 once rst_n is high.

## Timing
- Latency: with o_ready held high, a word accepted at edge N is presented on o_valid/o_data after edge N+DEPTH-1 and transfers at edge N+DEPTH. This holds in both modes; the skid slot adds no latency.
- Throughput: one word per cycle sustained when o_ready = 1.
- Combinational paths:
  - SKID=0: o_ready -> i_ready passes through DEPTH gates.
  - SKID=1: there is no path from o_ready to i_ready.
  - i_flush -> i_ready is combinational in both modes.
- Full:
  - SKID=0: i_ready = 0 when all v = 1 and o_ready = 0. If o_ready = 1 while full, i_ready = 1 and input is accepted in the same cycle.
  - SKID=1: i_ready falls at the edge after sv[0] sets. A word presented while full is held by upstream, never dropped.
- Empty: o_valid = 0 and o_count = 0. The o_ready value is ignored.
- Simultaneous input and output transfer at capacity is legal in SKID=0 only. o_count is unchanged.
- Backpressure release: after o_ready rises with the block full, one word leaves per cycle, in order.

## Test plan
- Reset/latency: DW=32, DEPTH=3, SKID=0, o_ready=1. Send 0x11111111 at edge 0 -> o_valid=1 with o_data=0x11111111 after edge 2. After reset: o_valid=0, o_data=0, o_count=0, i_ready=1.
- Streaming: 16 back-to-back words 0..15, o_ready=1, both modes -> 16 outputs in order, one per cycle, no bubbles, o_count steady at DEPTH once the pipeline is filled.
- Backpressure fill: DEPTH=2, SKID=1, o_ready=0, send 0xA..0xF -> 4 words accepted, o_count=4, i_ready=0. Then raise o_ready -> outputs 0xA, 0xB, 0xC, 0xD, and 0xE, 0xF follow in order.
- Full with simultaneous transfer: DEPTH=2, SKID=0, pipeline full, o_ready=1 and i_valid=1 -> in and out both transfer, o_count stays 2.
- Flush: hold 3 words, pulse i_flush while o_ready=1 and i_valid=1 -> head word delivered, input refused that cycle, next cycle o_valid=0, o_count=0, o_data unchanged.
- Random: random valid/ready at 50%/30%, SKID in {0,1}, DEPTH in {1,4,8}, 10k words -> scoreboard exact in-order match, o_count matches the model every cycle. Include an async reset mid-burst -> all state cleared immediately.
